// File: rtl/lut_neuron_pkg.sv
// Shared constants and types for the runtime-programmable LUT neuron.
package lut_neuron_pkg;

  localparam int unsigned DEF_IN_BITS  = 6;
  localparam int unsigned DEF_OUT_BITS = 2;

  typedef logic [DEF_OUT_BITS-1:0] entry_t;

  function automatic int unsigned table_depth(int unsigned in_bits);
    return 32'd1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// Truth-table storage: synchronous write, asynchronous read, async clear.
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = DEF_IN_BITS,
  parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = table_depth(IN_BITS);

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read lets a same-edge transfer capture the pre-write value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_pipe.sv
// Two-stage valid/ready pipeline around a runtime-writable neuron truth table.
module lut_neuron_pipe
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = DEF_IN_BITS,
  parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                cfg_we,
  input  logic [IN_BITS-1:0]  cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                busy
);

  logic                s1_valid;
  logic [IN_BITS-1:0]  s1_addr;
  logic                s1_adv;
  logic [OUT_BITS-1:0] rdata;

  lut_neuron_table #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_we),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(s1_addr),
    .rdata(rdata)
  );

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign busy     = s1_valid || out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_addr <= in_data;
      end
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) out_data <= rdata;
      end
    end
  end

endmodule
